// File: rtl/line_band_scheduler_if.sv
// Video timing, downstream ready and line-memory control bundle of the band scheduler.
// master = timing source / downstream side, slave = scheduler.
interface line_band_scheduler_if #(
   parameter int LINE_NUM = 12,
   parameter int CNT_W    = 11
);
   logic                i_sync_h;
   logic                i_sync_v;
   logic                i_rd_ready;
   logic [LINE_NUM-1:0] o_wr_en;
   logic [LINE_NUM-1:0] o_line_full;
   logic                o_rd_en;
   logic [CNT_W-1:0]    o_rd_h_count;
   logic [CNT_W-1:0]    o_rd_v_base;
   logic                o_band_done;
   logic                o_overflow;
   logic [1:0]          o_state;

   modport master (
      output i_sync_h, i_sync_v, i_rd_ready,
      input  o_wr_en, o_line_full, o_rd_en, o_rd_h_count, o_rd_v_base,
             o_band_done, o_overflow, o_state
   );

   modport slave (
      input  i_sync_h, i_sync_v, i_rd_ready,
      output o_wr_en, o_line_full, o_rd_en, o_rd_h_count, o_rd_v_base,
             o_band_done, o_overflow, o_state
   );
endinterface

// File: rtl/line_band_scheduler.sv
// Band buffer sequencer: round-robin line writes, one IMG_W-cycle read burst per full band.
// o_wr_en is combinational from registered wr_line; read side waits in WAIT until i_rd_ready.
module line_band_scheduler #(
   parameter int LINE_NUM = 12,
   parameter int IMG_W    = 1920,
   parameter int IMG_H    = 1080,
   parameter int CNT_W    = 11
) (
   input logic                  i_clk,
   input logic                  i_rst_n,
   line_band_scheduler_if.slave bus
);
   localparam int IDX_W = (LINE_NUM > 1) ? $clog2(LINE_NUM) : 1;
   localparam logic [IDX_W-1:0] LAST_LINE = IDX_W'(LINE_NUM - 1);
   localparam logic [CNT_W-1:0] LAST_PIX  = CNT_W'(IMG_W - 1);
   localparam logic [CNT_W:0]   LINE_STEP = (CNT_W + 1)'(LINE_NUM);
   localparam logic [CNT_W:0]   FRAME_H   = (CNT_W + 1)'(IMG_H);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      READ = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t              state;
   logic [IDX_W-1:0]    wr_line;
   logic                h_prev;
   logic                v_prev;
   logic [LINE_NUM-1:0] line_full;
   logic [CNT_W-1:0]    rd_h_count;
   logic [CNT_W-1:0]    rd_v_base;
   logic                rd_en;
   logic                band_done;
   logic                overflow;

   logic                line_end;
   logic                frame_start;
   logic                band_clear;
   logic                slot_busy;
   logic [LINE_NUM-1:0] line_onehot;
   logic [LINE_NUM-1:0] full_nxt;
   logic [CNT_W:0]      v_sum;

   assign line_end    = h_prev & ~bus.i_sync_h & bus.i_sync_v;
   assign frame_start = ~v_prev & bus.i_sync_v;
   assign band_clear  = (state == DONE);
   assign line_onehot = {{(LINE_NUM-1){1'b0}}, 1'b1} << wr_line;
   assign slot_busy   = |(line_full & line_onehot);
   assign v_sum       = {1'b0, rd_v_base} + LINE_STEP;

   // A line finishing on the DONE cycle must survive the band release.
   always_comb begin
      full_nxt = band_clear ? '0 : line_full;
      if (line_end) begin
         full_nxt = full_nxt | line_onehot;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state      <= IDLE;
         wr_line    <= '0;
         h_prev     <= 1'b0;
         v_prev     <= 1'b0;
         line_full  <= '0;
         rd_h_count <= '0;
         rd_v_base  <= '0;
         rd_en      <= 1'b0;
         band_done  <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         h_prev    <= bus.i_sync_h;
         v_prev    <= bus.i_sync_v;
         line_full <= full_nxt;
         band_done <= 1'b0;

         if (line_end && slot_busy && !band_clear) begin
            overflow <= 1'b1;
         end

         if (frame_start) begin
            wr_line <= '0;
         end else if (line_end) begin
            wr_line <= (wr_line == LAST_LINE) ? '0 : wr_line + 1'b1;
         end

         case (state)
            IDLE: begin
               if (&line_full) begin
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (bus.i_rd_ready) begin
                  state      <= READ;
                  rd_en      <= 1'b1;
                  rd_h_count <= '0;
               end
            end
            READ: begin
               if (rd_h_count == LAST_PIX) begin
                  state     <= DONE;
                  rd_en     <= 1'b0;
                  band_done <= 1'b1;
               end else begin
                  rd_h_count <= rd_h_count + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase

         // Frame start takes priority over the band advance.
         if (frame_start) begin
            rd_v_base <= '0;
         end else if (band_clear) begin
            rd_v_base <= (v_sum >= FRAME_H) ? '0 : v_sum[CNT_W-1:0];
         end
      end
   end

   assign bus.o_wr_en      = (i_rst_n && bus.i_sync_h && bus.i_sync_v) ? line_onehot : '0;
   assign bus.o_line_full  = line_full;
   assign bus.o_rd_en      = rd_en;
   assign bus.o_rd_h_count = rd_h_count;
   assign bus.o_rd_v_base  = rd_v_base;
   assign bus.o_band_done  = band_done;
   assign bus.o_overflow   = overflow;
   assign bus.o_state      = state;
endmodule

// File: tb/tb_line_band_scheduler.sv
// Directed bench: full-size instance for fill/burst/overflow/coincidence, short-line instance for the frame wrap.
module tb_line_band_scheduler;
   logic clk;
   logic rst_n;
   logic sel;
   logic sync_h;
   logic sync_v;
   logic rd_ready;

   int n_checks = 0;
   int n_errors = 0;

   line_band_scheduler_if #(.LINE_NUM(12), .CNT_W(11)) bif ();
   line_band_scheduler_if #(.LINE_NUM(12), .CNT_W(11)) sif ();

   assign bif.i_sync_h   = sync_h & ~sel;
   assign bif.i_sync_v   = sync_v & ~sel;
   assign bif.i_rd_ready = rd_ready & ~sel;
   assign sif.i_sync_h   = sync_h & sel;
   assign sif.i_sync_v   = sync_v & sel;
   assign sif.i_rd_ready = rd_ready & sel;

   line_band_scheduler #(.LINE_NUM(12), .IMG_W(1920), .IMG_H(1080), .CNT_W(11)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bif.slave)
   );

   line_band_scheduler #(.LINE_NUM(12), .IMG_W(4), .IMG_H(1080), .CNT_W(11)) dut_s (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (sif.slave)
   );

   logic [11:0] wr_en_m, full_m;
   logic [10:0] h_cnt_m, v_base_m;
   logic        rd_en_m, done_m, ovf_m;
   logic [1:0]  state_m;

   assign wr_en_m  = sel ? sif.o_wr_en      : bif.o_wr_en;
   assign full_m   = sel ? sif.o_line_full  : bif.o_line_full;
   assign h_cnt_m  = sel ? sif.o_rd_h_count : bif.o_rd_h_count;
   assign v_base_m = sel ? sif.o_rd_v_base  : bif.o_rd_v_base;
   assign rd_en_m  = sel ? sif.o_rd_en      : bif.o_rd_en;
   assign done_m   = sel ? sif.o_band_done  : bif.o_band_done;
   assign ovf_m    = sel ? sif.o_overflow   : bif.o_overflow;
   assign state_m  = sel ? sif.o_state      : bif.o_state;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One line of npix valid pixels followed by a two-cycle blank gap.
   task automatic send_line(input int npix, input bit chk, input logic [11:0] exp_wr);
      sync_h = 1'b1;
      #1;
      if (chk) check_val("wr_en_walk", 32'(wr_en_m), 32'(exp_wr));
      repeat (npix) tick();
      sync_h = 1'b0;
      repeat (2) tick();
   endtask

   task automatic run_burst(input int len, input bit coincide,
                            output int n, output int bad, output logic done_seen);
      n   = 0;
      bad = 0;
      rd_ready = 1'b1;
      tick();
      rd_ready = 1'b0;
      while (rd_en_m && n < 4000) begin
         if (int'(h_cnt_m) != n) bad++;
         if (coincide && int'(h_cnt_m) == len - 1) sync_h = 1'b1;
         n++;
         tick();
      end
      done_seen = done_m;
      sync_h = 1'b0;
      tick();
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          n, bad, wrap_bad;
      logic        done_seen;
      logic [11:0] e;

      sel = 1'b0; sync_h = 1'b0; sync_v = 1'b0; rd_ready = 1'b0; rst_n = 1'b0;

      // Reset with random inputs
      for (int i = 0; i < 3; i++) begin
         sync_h   = 1'($urandom_range(0, 1));
         sync_v   = 1'($urandom_range(0, 1));
         rd_ready = 1'($urandom_range(0, 1));
         tick();
      end
      check_val("rst_wr_en", 32'(wr_en_m), 0);
      check_val("rst_full", 32'(full_m), 0);
      check_val("rst_rd_en", 32'(rd_en_m), 0);
      check_val("rst_h_cnt", 32'(h_cnt_m), 0);
      check_val("rst_v_base", 32'(v_base_m), 0);
      check_val("rst_done", 32'(done_m), 0);
      check_val("rst_ovf", 32'(ovf_m), 0);
      check_val("rst_state", 32'(state_m), 0);

      sync_h = 1'b0; sync_v = 1'b0; rd_ready = 1'b0; rst_n = 1'b1;
      tick();
      sync_h = 1'b1;
      #1;
      check_val("wr_en_no_v", 32'(wr_en_m), 0);
      sync_h = 1'b0; sync_v = 1'b1;
      tick(); tick();
      check_val("wr_en_no_h", 32'(wr_en_m), 0);

      // Fill one band with full-width lines
      for (int k = 0; k < 12; k++) begin
         e = 12'b1 << k;
         send_line(1920, 1'b1, e);
      end
      check_val("fill_full", 32'(full_m), 32'hFFF);
      check_val("fill_state", 32'(state_m), 1);
      repeat (20) tick();
      check_val("wait_hold_state", 32'(state_m), 1);
      check_val("wait_hold_rd_en", 32'(rd_en_m), 0);

      // Burst
      run_burst(1920, 1'b0, n, bad, done_seen);
      check_val("burst_len", 32'(n), 1920);
      check_val("burst_h_seq", 32'(bad), 0);
      check_val("burst_done", 32'(done_seen), 1);
      check_val("burst_done_pulse", 32'(done_m), 0);
      check_val("burst_full_clr", 32'(full_m), 0);
      check_val("burst_v_base", 32'(v_base_m), 12);
      check_val("burst_state", 32'(state_m), 0);

      // Overflow on the 13th line
      for (int k = 0; k < 12; k++) send_line(8, 1'b0, 12'h0);
      check_val("ovf_pre", 32'(ovf_m), 0);
      send_line(8, 1'b0, 12'h0);
      check_val("ovf_set", 32'(ovf_m), 1);
      check_val("ovf_full", 32'(full_m), 32'hFFF);
      sync_h = 1'b1;
      #1;
      check_val("ovf_wr_line", 32'(wr_en_m), 32'h002);
      sync_h = 1'b0;
      tick(); tick();

      // Line end coincident with the DONE clear
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      for (int k = 0; k < 12; k++) send_line(4, 1'b0, 12'h0);
      check_val("coin_state", 32'(state_m), 1);
      run_burst(1920, 1'b1, n, bad, done_seen);
      check_val("coin_len", 32'(n), 1920);
      check_val("coin_full", 32'(full_m), 32'h001);
      check_val("coin_ovf", 32'(ovf_m), 0);
      check_val("coin_v_base", 32'(v_base_m), 12);

      // Frame wrap on the short-burst instance
      sel = 1'b1;
      tick();
      check_val("wrap_v_base0", 32'(v_base_m), 0);
      wrap_bad = 0;
      for (int b = 0; b < 90; b++) begin
         for (int k = 0; k < 12; k++) send_line(2, 1'b0, 12'h0);
         run_burst(4, 1'b0, n, bad, done_seen);
         if (n != 4 || bad != 0 || done_seen !== 1'b1) wrap_bad++;
         check_val("wrap_v_base", 32'(v_base_m), 32'(((b + 1) * 12) % 1080));
      end
      check_val("wrap_bursts", 32'(wrap_bad), 0);

      // Frame start mid-band
      for (int k = 0; k < 12; k++) send_line(2, 1'b0, 12'h0);
      run_burst(4, 1'b0, n, bad, done_seen);
      check_val("fs_v_base_pre", 32'(v_base_m), 12);
      for (int k = 0; k < 5; k++) send_line(2, 1'b0, 12'h0);
      check_val("fs_full_pre", 32'(full_m), 32'h01F);
      sync_v = 1'b0;
      tick(); tick();
      sync_v = 1'b1;
      tick();
      check_val("fs_v_base", 32'(v_base_m), 0);
      check_val("fs_full_kept", 32'(full_m), 32'h01F);
      sync_h = 1'b1;
      #1;
      check_val("fs_wr_line", 32'(wr_en_m), 32'h001);
      sync_h = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/line_band_scheduler.md
Name: line_band_scheduler

Overview:
- Single-clock controller that sequences a bank of LINE_NUM line memories used as a band buffer.
- Write side: steers incoming video lines round-robin into the memories via one-hot write enables and tracks which lines hold a complete line.
- Read side: when all lines are full and downstream is ready, issues one IMG_W-cycle read burst, releases the band and advances the vertical band base.
- Sits between the video timing input and the line memory bank, feeding the downstream band/kernel stage.

Parameters:
- LINE_NUM, 12, number of line memories per band.
- IMG_W, 1920, active pixels per line; read burst length.
- IMG_H, 1080, active lines per frame; must be a multiple of LINE_NUM.
- CNT_W, 11, width of the horizontal and vertical counters.

Ports:
- i_clk  in  1  single clock for write and read sequencing.
- i_rst_n  in  1  synchronous active-low reset.
- i_sync_h  in  1  active-high pixel-valid within a line.
- i_sync_v  in  1  active-high frame-valid.
- i_rd_ready  in  1  downstream can accept a band burst.
- o_wr_en  out  LINE_NUM  one-hot write enable to the line memories.
- o_line_full  out  LINE_NUM  per-line "complete line stored" flags.
- o_rd_en  out  1  read enable, common to all memories.
- o_rd_h_count  out  CNT_W  pixel index of the current read.
- o_rd_v_base  out  CNT_W  first image row of the band being read.
- o_band_done  out  1  one-cycle pulse at burst end.
- o_overflow  out  1  sticky error flag.
- o_state  out  2  FSM state, for debug.

Behaviour:
- Reset (i_rst_n=0 at a clock edge): all outputs 0, state IDLE, write index wr_line=0, h_prev=0, v_prev=0.
- Reset mid-burst aborts immediately; no o_band_done is issued.
- Write enable:
  - o_wr_en = onehot(wr_line) when i_sync_h & i_sync_v, else 0.
  - Combinational from the registered wr_line.
- Line end: h_prev=1, i_sync_h=0, i_sync_v=1. On line end:
  - set o_line_full[wr_line];
  - wr_line advances, wrapping LINE_NUM-1 -> 0.
- Frame start (v_prev=0, i_sync_v=1): wr_line <= 0 and o_rd_v_base <= 0. o_line_full is not touched.
- Overflow: a line end while o_line_full[wr_line] is already 1 and not being cleared that cycle sets o_overflow. The flag is cleared only by reset; the full bit stays 1.
- FSM encoding: IDLE=0, WAIT=1, READ=2, DONE=3.
- IDLE -> WAIT when o_line_full is all ones.
- WAIT -> READ on the first cycle with i_rd_ready=1; o_rd_h_count <= 0.
- i_rd_ready is sampled only in WAIT. Deassertion during READ is ignored.
- READ:
  - o_rd_en=1, registered; it first asserts the cycle after i_rd_ready is sampled high.
  - o_rd_h_count increments each cycle.
  - On the cycle o_rd_h_count==IMG_W-1: go to DONE, o_rd_en <= 0, count holds.
  - A burst is exactly IMG_W cycles of o_rd_en.
- DONE (one cycle):
  - o_band_done=1.
  - All o_line_full bits clear.
  - o_rd_v_base <= o_rd_v_base+LINE_NUM, or 0 if that sum >= IMG_H (1068 -> 0 at defaults).
  - -> IDLE.
- Line end coincident with the DONE clear: the set wins for that bit, so the new line survives.
- Frame start coincident with DONE: the frame start wins, o_rd_v_base=0.
- Memory read latency is owned by downstream; this block does not delay o_rd_en.
- All width arithmetic is unsigned CNT_W and must not truncate for the default parameters.

Test Plan:
- Reset: hold i_rst_n=0 for 3 clocks with random inputs -> all outputs 0, o_state=0; release -> no o_wr_en until i_sync_h & i_sync_v.
- Fill band: 12 lines of 1920 valid pixels with i_rd_ready=0:
  - o_wr_en walks 0x001..0x800;
  - o_line_full reaches 0xFFF;
  - o_state=1 and holds while i_rd_ready=0.
- Burst: assert i_rd_ready -> o_rd_en high exactly 1920 cycles, o_rd_h_count 0..1919, then o_band_done pulse, o_line_full=0x000, o_rd_v_base=12.
- Overflow: write 13 lines without reading -> 13th line end sets o_overflow=1, o_line_full stays 0xFFF, wr_line back to 1.
- Coincidence: time a line end into wr_line=0 on the DONE cycle -> o_line_full=0x001 afterwards, o_overflow stays 0.
- Frame wrap: run 90 bands -> o_rd_v_base sequence 0,12,...,1068,0; a frame-start pulse mid-band forces wr_line=0 and o_rd_v_base=0.
